// File: rtl/valu_pkg.sv
// Shared VALU definitions: opcode constants, sequencer state encoding and a
// legality helper used by both the control decoder and the execute unit.
package valu_pkg;

  localparam logic [2:0] VALU_ADD  = 3'b010;
  localparam logic [2:0] VALU_SUB  = 3'b110;
  localparam logic [2:0] VALU_SMUL = 3'b000;
  localparam logic [2:0] VALU_DOT  = 3'b001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } valu_state_e;

  function automatic logic valu_is_legal(input logic [2:0] code);
    logic legal_s;
    case (code)
      VALU_ADD, VALU_SUB, VALU_SMUL, VALU_DOT: legal_s = 1'b1;
      default:                                 legal_s = 1'b0;
    endcase
    return legal_s;
  endfunction

endpackage

// File: rtl/valu_lane.sv
// Single-element VALU datapath, time-multiplexed across the vector by the
// sequencer. Unsupported codes produce a zero element and leave acc untouched.
module valu_lane
  import valu_pkg::*;
#(
  parameter int ELEM_W = 32
) (
  input  logic [2:0]        op,
  input  logic [ELEM_W-1:0] a,
  input  logic [ELEM_W-1:0] b,
  input  logic [ELEM_W-1:0] scalar,
  input  logic [ELEM_W-1:0] acc_in,
  output logic [ELEM_W-1:0] elem_out,
  output logic [ELEM_W-1:0] acc_out
);

  // Element result and running dot-product sum, all modulo 2^ELEM_W
  always_comb begin
    elem_out = {ELEM_W{1'b0}};
    acc_out  = acc_in;
    case (op)
      VALU_ADD:  elem_out = a + b;
      VALU_SUB:  elem_out = a - b;
      VALU_SMUL: elem_out = a * scalar;
      VALU_DOT:  acc_out  = acc_in + a * b;
      default: begin
        elem_out = {ELEM_W{1'b0}};
        acc_out  = acc_in;
      end
    endcase
  end

endmodule

// File: rtl/valu_seq_exec_chk.sv
// Protocol invariants of the VALU sequencer outputs, bound from outside.
module valu_seq_exec_chk (
  input logic clk_i,
  input logic rst_i,
  input logic ready_o,
  input logic busy_o,
  input logic done_o,
  input logic illegal_o
);

  a_ready_busy_excl: assert property (@(posedge clk_i) disable iff (rst_i)
    !(ready_o && busy_o));

  a_done_quiet: assert property (@(posedge clk_i) disable iff (rst_i)
    done_o |-> (!ready_o && !busy_o));

  a_done_pulse: assert property (@(posedge clk_i) disable iff (rst_i)
    done_o |=> !done_o);

  a_illegal_in_done: assert property (@(posedge clk_i) disable iff (rst_i)
    illegal_o |-> done_o);

endmodule

// File: rtl/valu_seq_exec.sv
// Sequential vector ALU: latches one request, walks its elements through a
// single lane one per cycle, then presents the vector with a done pulse.
module valu_seq_exec
  import valu_pkg::*;
#(
  parameter int NUM_ELEM = 4,
  parameter int ELEM_W   = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [2:0]                   valu_ctrl_i,
  input  logic [NUM_ELEM*ELEM_W-1:0]   vs1_i,
  input  logic [NUM_ELEM*ELEM_W-1:0]   vs2_i,
  input  logic [ELEM_W-1:0]            rs_i,
  output logic [NUM_ELEM*ELEM_W-1:0]   result_o,
  output logic                         done_o,
  output logic                         busy_o,
  output logic                         illegal_o
);

  localparam int VEC_W = NUM_ELEM * ELEM_W;
  localparam int IDX_W = (NUM_ELEM > 1) ? $clog2(NUM_ELEM) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ELEM - 1);

  valu_state_e        state_r;
  logic [IDX_W-1:0]   idx_r;
  logic [2:0]         op_r;
  logic [VEC_W-1:0]   vs1_r;
  logic [VEC_W-1:0]   vs2_r;
  logic [ELEM_W-1:0]  rs_r;
  logic [ELEM_W-1:0]  acc_r;
  logic [VEC_W-1:0]   work_r;
  logic [VEC_W-1:0]   result_r;
  logic               done_r;
  logic               busy_r;
  logic               ready_r;
  logic               illegal_r;

  logic [ELEM_W-1:0]  a_s;
  logic [ELEM_W-1:0]  b_s;
  logic [ELEM_W-1:0]  elem_s;
  logic [ELEM_W-1:0]  acc_nxt_s;
  logic [VEC_W-1:0]   work_nxt_s;
  logic [VEC_W-1:0]   final_vec_s;

  assign a_s = vs1_r[idx_r*ELEM_W +: ELEM_W];
  assign b_s = vs2_r[idx_r*ELEM_W +: ELEM_W];

  valu_lane #(
    .ELEM_W (ELEM_W)
  ) u_lane (
    .op       (op_r),
    .a        (a_s),
    .b        (b_s),
    .scalar   (rs_r),
    .acc_in   (acc_r),
    .elem_out (elem_s),
    .acc_out  (acc_nxt_s)
  );

  // Working vector with the current element merged in; element 0 carries the
  // dot-product sum, every other dot element stays at its cleared zero
  always_comb begin
    work_nxt_s = work_r;
    work_nxt_s[idx_r*ELEM_W +: ELEM_W] = elem_s;
    final_vec_s = work_nxt_s;
    final_vec_s[ELEM_W-1:0] = (op_r == VALU_DOT) ? acc_nxt_s : work_nxt_s[ELEM_W-1:0];
  end

  // Sequencer FSM with registered handshake and result outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      idx_r     <= {IDX_W{1'b0}};
      op_r      <= 3'b000;
      vs1_r     <= {VEC_W{1'b0}};
      vs2_r     <= {VEC_W{1'b0}};
      rs_r      <= {ELEM_W{1'b0}};
      acc_r     <= {ELEM_W{1'b0}};
      work_r    <= {VEC_W{1'b0}};
      result_r  <= {VEC_W{1'b0}};
      done_r    <= 1'b0;
      busy_r    <= 1'b0;
      ready_r   <= 1'b1;
      illegal_r <= 1'b0;
    end else begin
      done_r    <= 1'b0;
      illegal_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (valid_i) begin
            op_r    <= valu_ctrl_i;
            vs1_r   <= vs1_i;
            vs2_r   <= vs2_i;
            rs_r    <= rs_i;
            idx_r   <= {IDX_W{1'b0}};
            acc_r   <= {ELEM_W{1'b0}};
            work_r  <= {VEC_W{1'b0}};
            state_r <= EXEC;
            busy_r  <= 1'b1;
            ready_r <= 1'b0;
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
          end
        end
        EXEC: begin
          work_r <= work_nxt_s;
          acc_r  <= acc_nxt_s;
          if (idx_r == LAST_IDX) begin
            // Outputs are registered, so the finished vector is captured on
            // the same edge that enters DONE
            idx_r     <= {IDX_W{1'b0}};
            state_r   <= DONE;
            result_r  <= final_vec_s;
            done_r    <= 1'b1;
            illegal_r <= ~valu_is_legal(op_r);
            busy_r    <= 1'b0;
            ready_r   <= 1'b0;
          end else begin
            idx_r <= idx_r + 1'b1;
          end
        end
        DONE: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
          ready_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o   = ready_r;
  assign busy_o    = busy_r;
  assign done_o    = done_r;
  assign illegal_o = illegal_r;
  assign result_o  = result_r;

endmodule

// File: tb/tb_valu_seq_exec.sv
// Randomized bench for valu_seq_exec against a cycle-count behavioural model,
// plus directed requests whose results are pinned to hand-computed vectors.
module tb_valu_seq_exec;

  localparam int NE = 4;
  localparam int EW = 32;
  localparam int VW = NE * EW;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          valid_i = 1'b0;
  logic [2:0]    valu_ctrl_i = 3'b000;
  logic [VW-1:0] vs1_i = '0;
  logic [VW-1:0] vs2_i = '0;
  logic [EW-1:0] rs_i = '0;
  logic          ready_o, done_o, busy_o, illegal_o;
  logic [VW-1:0] result_o;

  valu_seq_exec #(.NUM_ELEM(NE), .ELEM_W(EW)) dut (
    .clk_i(clk), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .valu_ctrl_i(valu_ctrl_i), .vs1_i(vs1_i), .vs2_i(vs2_i), .rs_i(rs_i),
    .result_o(result_o), .done_o(done_o), .busy_o(busy_o), .illegal_o(illegal_o)
  );

  valu_seq_exec_chk u_chk (
    .clk_i(clk), .rst_i(rst_i), .ready_o(ready_o), .busy_o(busy_o),
    .done_o(done_o), .illegal_o(illegal_o)
  );

  always #5 clk = ~clk;

  // Pinned expectations, indexed by request number (written by stimulus only)
  logic          pin_en  [0:127];
  logic [VW-1:0] pin_res [0:127];
  logic          pin_ill [0:127];
  int            req_n = 0;

  int compared = 0;
  int mismatched = 0;

  function automatic logic [VW-1:0] ref_result(input logic [2:0] op, input logic [VW-1:0] a,
                                               input logic [VW-1:0] b, input logic [EW-1:0] s);
    logic [VW-1:0] r;
    logic [EW-1:0] acc, x, y, p;
    r = '0;
    acc = '0;
    for (int i = 0; i < NE; i++) begin
      x = a[i*EW +: EW];
      y = b[i*EW +: EW];
      case (op)
        3'b010: r[i*EW +: EW] = x + y;
        3'b110: r[i*EW +: EW] = x - y;
        3'b000: begin p = x * s; r[i*EW +: EW] = p; end
        3'b001: begin p = x * y; acc = acc + p; end
        default: ;
      endcase
    end
    if (op == 3'b001) r[EW-1:0] = acc;
    return r;
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return !(op == 3'b010 || op == 3'b110 || op == 3'b000 || op == 3'b001);
  endfunction

  function automatic logic [VW-1:0] vec4(input int e3, input int e2, input int e1, input int e0);
    return {e3[EW-1:0], e2[EW-1:0], e1[EW-1:0], e0[EW-1:0]};
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Model state: phase 0 idle, 1..4 executing, 5 done
  int            cyc = 0;
  int            phase = 0;
  bit            known = 1'b0;
  logic [VW-1:0] exp_res = '0;
  logic          exp_ill = 1'b0;
  logic [VW-1:0] pend_res = '0;
  logic          pend_ill = 1'b0;
  int            acc_cyc = 0;
  int            n_acc = 0;
  int            cur_id = 0;

  task automatic chk(input string nm, input logic [VW-1:0] got, input logic [VW-1:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", nm, cyc, got, exp);
    end
  endtask

  // Compare process: check outputs against the model, then advance the model
  initial begin : cmp
    forever begin
      @(negedge clk);
      cyc++;
      if (known) begin
        chk("ready", VW'(ready_o), VW'(phase == 0));
        chk("busy", VW'(busy_o), VW'(phase >= 1 && phase <= 4));
        chk("done", VW'(done_o), VW'(phase == 5));
        chk("illegal", VW'(illegal_o), VW'((phase == 5) && exp_ill));
        chk("result", result_o, exp_res);
        if (done_o === 1'b1 && phase == 5) begin
          chk("latency", VW'(cyc - acc_cyc), VW'(5));
          if (pin_en[cur_id]) begin
            chk("pin_result", result_o, pin_res[cur_id]);
            chk("pin_illegal", VW'(illegal_o), VW'(pin_ill[cur_id]));
          end
        end
      end
      if (rst_i) begin
        known = 1'b1;
        phase = 0;
        exp_res = '0;
        exp_ill = 1'b0;
      end else if (known) begin
        case (phase)
          0: if (valid_i) begin
               pend_res = ref_result(valu_ctrl_i, vs1_i, vs2_i, rs_i);
               pend_ill = is_illegal(valu_ctrl_i);
               acc_cyc = cyc;
               cur_id = n_acc;
               n_acc++;
               phase = 1;
             end
          1, 2, 3: phase++;
          4: begin
               phase = 5;
               exp_res = pend_res;
               exp_ill = pend_ill;
             end
          default: phase = 0;
        endcase
      end
    end
  end

  task automatic do_req(input logic [2:0] op, input logic [VW-1:0] a, input logic [VW-1:0] b,
                        input logic [EW-1:0] s, input bit pin, input logic [VW-1:0] pres,
                        input bit pill, input bit tog);
    int waited;
    pin_en[req_n] = pin;
    pin_res[req_n] = pres;
    pin_ill[req_n] = pill;
    @(posedge clk); #1;
    valid_i = 1'b1; valu_ctrl_i = op; vs1_i = a; vs2_i = b; rs_i = s;
    waited = 0;
    do begin
      @(negedge clk);
      waited++;
    end while (ready_o !== 1'b1 && waited < 50);
    if (ready_o !== 1'b1) begin
      $display("FAIL accept_timeout cyc=%0d got ready=%b exp ready=1", cyc, ready_o);
      $fatal(1);
    end
    @(posedge clk); #1;
    req_n++;
    if (tog) begin
      for (int i = 0; i < 4; i++) begin
        valid_i = 1'($urandom_range(0, 1));
        valu_ctrl_i = 3'($urandom_range(0, 7));
        vs1_i = rand_vec(); vs2_i = rand_vec(); rs_i = $urandom;
        @(posedge clk); #1;
      end
    end
    valid_i = 1'b0;
  endtask

  initial begin : stim
    for (int i = 0; i < 128; i++) begin
      pin_en[i] = 1'b0; pin_res[i] = '0; pin_ill[i] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    do_req(3'b010, vec4(4, 3, 2, 1), vec4(40, 30, 20, 10), 32'd0, 1'b1,
           vec4(44, 33, 22, 11), 1'b0, 1'b0);
    do_req(3'b110, vec4(0, 0, 0, 5), vec4(1, 1, 1, 2), 32'd0, 1'b1,
           {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3}, 1'b0, 1'b0);
    do_req(3'b000, vec4(4, 3, 2, 1), vec4(9, 9, 9, 9), 32'd3, 1'b1,
           vec4(12, 9, 6, 3), 1'b0, 1'b0);
    do_req(3'b001, vec4(4, 3, 2, 1), vec4(8, 7, 6, 5), 32'd0, 1'b1,
           vec4(0, 0, 0, 70), 1'b0, 1'b0);
    do_req(3'b110, vec4(8, 6, 4, 2), vec4(1, 1, 1, 1), 32'd0, 1'b1,
           vec4(7, 5, 3, 1), 1'b0, 1'b1);
    do_req(3'b101, vec4(4, 3, 2, 1), vec4(40, 30, 20, 10), 32'd7, 1'b1,
           '0, 1'b1, 1'b0);

    // Abort while element 2 is being computed
    do_req(3'b010, rand_vec(), rand_vec(), $urandom, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_i = 1'b1;
    @(posedge clk); #1;
    rst_i = 1'b0;
    repeat (8) @(posedge clk);

    for (int n = 0; n < 40; n++) begin
      do_req(3'($urandom_range(0, 7)), rand_vec(), rand_vec(), $urandom,
             1'b0, '0, 1'b0, ($urandom_range(0, 3) == 0));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end

    repeat (10) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
